// File: rtl/mac_pe_row.sv
// Weight-stationary row of NUM_PE MAC cells: weights shift in once and then stay put,
// activations ripple west->east one PE per cycle, and each PE adds to a partial sum from above.
module mac_pe_row #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned NUM_PE    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mode_signed,
    input  logic                          sat_en,
    input  logic                          clr_ovf,
    input  logic                          wt_load_valid,
    input  logic [BIT_WIDTH-1:0]          wt_load_data,
    output logic                          wt_load_ready,
    output logic                          wt_loaded,
    input  logic                          data_in_valid,
    input  logic [BIT_WIDTH-1:0]          data_in,
    input  logic [NUM_PE*ACC_WIDTH-1:0]   acc_in,
    output logic [NUM_PE*ACC_WIDTH-1:0]   acc_out,
    output logic [NUM_PE-1:0]             acc_out_valid,
    output logic [BIT_WIDTH-1:0]          data_out,
    output logic                          data_out_valid,
    output logic                          ovf_flag
);

    localparam int unsigned PROD_W = 2 * BIT_WIDTH;
    localparam int unsigned EXT_W  = ACC_WIDTH + 1 - PROD_W;
    localparam int unsigned CNT_W  = $clog2(NUM_PE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 mode_q, mode_d;
    logic                                 wt_accept;

    logic [NUM_PE-1:0][BIT_WIDTH-1:0]     w_q;
    logic [NUM_PE-1:0][BIT_WIDTH-1:0]     a_q;
    logic [NUM_PE-1:0][BIT_WIDTH-1:0]     a_at;
    logic [NUM_PE-1:0]                    v_q;
    logic [NUM_PE-1:0]                    v_at;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]     acc_q;
    logic [NUM_PE-1:0][ACC_WIDTH-1:0]     res_vec;
    logic [NUM_PE-1:0]                    ovf_vec;
    logic [NUM_PE-1:0]                    vld_q;
    logic [BIT_WIDTH-1:0]                 dout_q;
    logic                                 dout_vld_q;
    logic                                 ovf_q;

    // Weights may only be replaced once no activation is in flight anywhere in the row.
    assign wt_load_ready = reset && ((state_q != ST_READY) || (!(|v_q) && !data_in_valid));
    assign wt_accept     = wt_load_valid && wt_load_ready;
    assign wt_loaded     = (state_q == ST_READY);

    // Operand seen by PE k this cycle: PE0 takes the port directly, later PEs the previous stage.
    assign a_at = {a_q[NUM_PE-2:0], data_in};
    assign v_at = {v_q[NUM_PE-2:0], data_in_valid & wt_loaded};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (wt_accept) begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    state_d = ST_LOAD;
                    cnt_d   = CNT_W'(1);
                    mode_d  = mode_signed;
                end
                ST_LOAD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_PE - 1)) begin
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        logic signed [PROD_W-1:0]  prod_s;
        logic [PROD_W-1:0]         prod_u;
        logic [ACC_WIDTH-1:0]      acc_k;
        logic [ACC_WIDTH:0]        sum;
        logic [ACC_WIDTH-1:0]      sat_val;
        logic [ACC_WIDTH-1:0]      res;
        logic                      ovf;

        assign acc_k  = acc_in[k*ACC_WIDTH +: ACC_WIDTH];
        assign prod_s = PROD_W'($signed(a_at[k])) * PROD_W'($signed(w_q[k]));
        assign prod_u = PROD_W'(a_at[k]) * PROD_W'(w_q[k]);

        // One extra sum bit exposes overflow in either signedness.
        always_comb begin
            sum     = '0;
            ovf     = 1'b0;
            sat_val = '0;
            if (mode_q) begin
                sum     = {{EXT_W{prod_s[PROD_W-1]}}, prod_s} + {acc_k[ACC_WIDTH-1], acc_k};
                ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
                sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin
                sum     = {{EXT_W{1'b0}}, prod_u} + {1'b0, acc_k};
                ovf     = sum[ACC_WIDTH];
                sat_val = '1;
            end
            res = (ovf && sat_en) ? sat_val : sum[ACC_WIDTH-1:0];
        end

        assign res_vec[k] = res;
        assign ovf_vec[k] = ovf;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q        <= '0;
            a_q        <= '0;
            v_q        <= '0;
            acc_q      <= '0;
            vld_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wt_accept) begin
                w_q <= {w_q[NUM_PE-2:0], wt_load_data};
            end
            a_q   <= a_at;
            v_q   <= v_at;
            vld_q <= v_at;
            for (int k = 0; k < NUM_PE; k++) begin
                if (v_at[k]) begin
                    acc_q[k] <= res_vec[k];
                end
            end
            if (v_q[NUM_PE-1]) begin
                dout_q <= a_q[NUM_PE-1];
            end
            dout_vld_q <= v_q[NUM_PE-1];
            // A fresh overflow outranks a same-cycle clear.
            ovf_q <= (|(ovf_vec & v_at)) | (ovf_q & ~clr_ovf);
        end
    end

    assign acc_out        = acc_q;
    assign acc_out_valid  = vld_q;
    assign data_out       = dout_q;
    assign data_out_valid = dout_vld_q;
    assign ovf_flag       = ovf_q;

endmodule

// File: tb/tb_mac_pe_row.sv
// Bench for mac_pe_row: directed scenarios plus randomized traffic against a cycle-level
// reference built from an activation history queue and plain integer arithmetic.
module tb_mac_pe_row;

    localparam int unsigned BW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned NP = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               mode_signed;
    logic               sat_en;
    logic               clr_ovf;
    logic               wt_load_valid;
    logic [BW-1:0]      wt_load_data;
    logic               wt_load_ready;
    logic               wt_loaded;
    logic               data_in_valid;
    logic [BW-1:0]      data_in;
    logic [NP*AW-1:0]   acc_in;
    logic [NP*AW-1:0]   acc_out;
    logic [NP-1:0]      acc_out_valid;
    logic [BW-1:0]      data_out;
    logic               data_out_valid;
    logic               ovf_flag;

    always #5 clk = ~clk;

    mac_pe_row #(.BIT_WIDTH(BW), .ACC_WIDTH(AW), .NUM_PE(NP)) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_signed    (mode_signed),
        .sat_en         (sat_en),
        .clr_ovf        (clr_ovf),
        .wt_load_valid  (wt_load_valid),
        .wt_load_data   (wt_load_data),
        .wt_load_ready  (wt_load_ready),
        .wt_loaded      (wt_loaded),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .acc_in         (acc_in),
        .acc_out        (acc_out),
        .acc_out_valid  (acc_out_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .ovf_flag       (ovf_flag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: weights held in PE order, number of words in the current load,
    // and a history of accepted activations (index j = accepted j cycles ago).
    typedef struct packed {
        logic          v;
        logic [BW-1:0] d;
    } act_t;

    act_t           hist[$];
    int             m_nwt;
    logic           m_mode;
    logic [BW-1:0]  m_w   [NP];
    logic [AW-1:0]  m_acc [NP];
    logic [NP-1:0]  m_av;
    logic [BW-1:0]  m_dout;
    logic           m_dv;
    logic           m_ovf;
    logic           exp_ready;
    logic [AW-1:0]  ev [NP];

    function automatic act_t hist_at(input int j);
        if (j < hist.size()) return hist[j];
        return '0;
    endfunction

    task automatic pe_ref(input logic sgn, input logic sat, input logic [BW-1:0] a,
                          input logic [BW-1:0] w, input logic [AW-1:0] acc,
                          output logic [AW-1:0] r, output logic ovf);
        longint p, s, mx, mn;
        if (sgn) begin
            p  = longint'($signed(a)) * longint'($signed(w));
            s  = longint'($signed(acc)) + p;
            mx = (longint'(1) << (AW - 1)) - 1;
            mn = -(longint'(1) << (AW - 1));
        end else begin
            p  = longint'(a) * longint'(w);
            s  = longint'(acc) + p;
            mx = (longint'(1) << AW) - 1;
            mn = 0;
        end
        ovf = (s > mx) || (s < mn);
        if (ovf && sat) s = (s > mx) ? mx : mn;
        r = s[AW-1:0];
    endtask

    task automatic model_step();
        logic          busy;
        logic          act;
        logic          o;
        logic          any_ovf;
        logic [AW-1:0] r;
        act_t          h;
        if (!reset) begin
            m_nwt = 0;
            m_mode = 1'b0;
            for (int k = 0; k < NP; k++) begin
                m_w[k]   = '0;
                m_acc[k] = '0;
            end
            m_av = '0;
            m_dout = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            hist.delete();
            exp_ready = 1'b0;
            return;
        end
        busy = 1'b0;
        for (int j = 0; j < NP; j++) busy |= hist_at(j).v;
        exp_ready = (m_nwt < NP) || (!busy && !data_in_valid);
        act = data_in_valid && (m_nwt == NP);
        hist.push_front({act, data_in});
        any_ovf = 1'b0;
        for (int k = 0; k < NP; k++) begin
            h = hist_at(k);
            m_av[k] = h.v;
            if (h.v) begin
                pe_ref(m_mode, sat_en, h.d, m_w[k], acc_in[k*AW +: AW], r, o);
                m_acc[k] = r;
                any_ovf |= o;
            end
        end
        h = hist_at(NP);
        m_dv = h.v;
        if (h.v) m_dout = h.d;
        m_ovf = any_ovf || (m_ovf && !clr_ovf);
        if (wt_load_valid && exp_ready) begin
            for (int k = NP - 1; k > 0; k--) m_w[k] = m_w[k-1];
            m_w[0] = wt_load_data;
            if (m_nwt == 0 || m_nwt == NP) begin
                m_mode = mode_signed;
                m_nwt = 1;
            end else begin
                m_nwt++;
            end
        end
        while (hist.size() > NP + 1) void'(hist.pop_back());
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NP; k++)
            chk($sformatf("acc_out[%0d]", k), acc_out[k*AW +: AW], m_acc[k]);
        chk("acc_out_valid", acc_out_valid, m_av);
        chk("data_out", data_out, m_dout);
        chk("data_out_valid", data_out_valid, m_dv);
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("wt_loaded", wt_loaded, m_nwt == NP);
    endtask

    task automatic cycle();
        #1;
        model_step();
        chk("wt_load_ready", wt_load_ready, exp_ready);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_acc_all(input logic [AW-1:0] v);
        for (int k = 0; k < NP; k++) acc_in[k*AW +: AW] = v;
    endtask

    task automatic load4(input string tag, input logic sgn, input logic [BW-1:0] a,
                         input logic [BW-1:0] b, input logic [BW-1:0] c, input logic [BW-1:0] d);
        logic [BW-1:0] ws [4];
        ws = '{a, b, c, d};
        mode_signed = sgn;
        for (int i = 0; i < 4; i++) begin
            wt_load_valid = 1'b1;
            wt_load_data = ws[i];
            cycle();
            chk($sformatf("%s_loaded%0d", tag, i), wt_loaded, i == NP - 1);
        end
        wt_load_valid = 1'b0;
    endtask

    // One activation, then each PE's result checked on its own cycle, then data_out.
    task automatic pulse(input string tag, input logic [BW-1:0] d);
        data_in_valid = 1'b1;
        data_in = d;
        cycle();
        data_in_valid = 1'b0;
        for (int k = 0; k < NP; k++) begin
            if (k > 0) cycle();
            chk($sformatf("%s_pe%0d", tag, k), acc_out[k*AW +: AW], ev[k]);
            chk($sformatf("%s_vld%0d", tag, k), acc_out_valid, NP'(1) << k);
        end
        cycle();
        chk($sformatf("%s_dout", tag), data_out, d);
        chk($sformatf("%s_dvld", tag), data_out_valid, 1'b1);
    endtask

    function automatic logic [AW-1:0] rand_acc();
        logic [AW-1:0] r;
        r = AW'($urandom);
        case ($urandom_range(0, 3))
            0: rand_acc = r;
            1: rand_acc = {8'h7F, 16'hFFFF, r[7:0]};
            2: rand_acc = {8'hFF, 16'hFFFF, r[7:0]};
            default: rand_acc = {8'h80, 16'h0000, r[7:0]};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int dv_pct [4];
        dv_pct = '{60, 30, 10, 90};
        reset = 1'b0;
        mode_signed = 1'b0;
        sat_en = 1'b0;
        clr_ovf = 1'b0;
        wt_load_valid = 1'b0;
        wt_load_data = '0;
        data_in_valid = 1'b0;
        data_in = '0;
        set_acc_all('0);
        run(2);
        reset = 1'b1;

        // Activation while IDLE is dropped.
        data_in_valid = 1'b1;
        data_in = 8'h33;
        cycle();
        chk("idle_no_valid", acc_out_valid, '0);
        data_in_valid = 1'b0;
        run(NP + 1);

        // Load 1,2,3,4 so PE0..PE3 hold 4,3,2,1; stream 5 with acc_in 10.
        load4("t1", 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        set_acc_all(32'd10);
        ev = '{32'd30, 32'd25, 32'd20, 32'd15};
        pulse("t2", 8'd5);
        set_acc_all('0);

        // Reload from READY (restarts the count); signed 0xFF * 0x80.
        load4("t3s", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        ev = '{32'd128, 32'd128, 32'd128, 32'd128};
        pulse("t3s", 8'h80);
        load4("t3u", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        ev = '{32'd32640, 32'd32640, 32'd32640, 32'd32640};
        pulse("t3u", 8'h80);

        // Signed saturation and wrap near the positive limit.
        load4("t4", 1'b1, 8'd1, 8'd1, 8'd1, 8'd1);
        set_acc_all(32'h7FFF_FFF0);
        sat_en = 1'b1;
        ev = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        pulse("t4sat", 8'h7F);
        chk("t4sat_ovf", ovf_flag, 1'b1);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        chk("t4_clr", ovf_flag, 1'b0);
        sat_en = 1'b0;
        ev = '{32'h8000_006F, 32'h8000_006F, 32'h8000_006F, 32'h8000_006F};
        pulse("t4wrap", 8'h7F);
        chk("t4wrap_ovf", ovf_flag, 1'b1);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        chk("t4_clr2", ovf_flag, 1'b0);

        // Weight offer while an activation is in flight must be refused.
        set_acc_all('0);
        data_in_valid = 1'b1;
        data_in = 8'd3;
        cycle();
        data_in_valid = 1'b0;
        wt_load_valid = 1'b1;
        wt_load_data = 8'h55;
        for (int i = 0; i < NP; i++) begin
            #1;
            chk("t5_ready_low", wt_load_ready, 1'b0);
            cycle();
        end
        wt_load_valid = 1'b0;
        chk("t5_still_loaded", wt_loaded, 1'b1);
        ev = '{32'd2, 32'd2, 32'd2, 32'd2};
        pulse("t5", 8'd2);

        // Reset in the middle of a load, with the overflow flag set.
        set_acc_all(32'h7FFF_FFF0);
        ev = '{32'h8000_006F, 32'h8000_006F, 32'h8000_006F, 32'h8000_006F};
        pulse("t6pre", 8'h7F);
        set_acc_all('0);
        wt_load_valid = 1'b1;
        wt_load_data = 8'd7;
        run(2);
        wt_load_valid = 1'b0;
        reset = 1'b0;
        cycle();
        chk("t6_acc", acc_out, '0);
        chk("t6_vld", acc_out_valid, '0);
        chk("t6_dout", data_out, '0);
        chk("t6_dvld", data_out_valid, 1'b0);
        chk("t6_ovf", ovf_flag, 1'b0);
        chk("t6_loaded", wt_loaded, 1'b0);
        chk("t6_ready", wt_load_ready, 1'b0);
        reset = 1'b1;
        load4("t6", 1'b0, 8'd2, 8'd2, 8'd2, 8'd2);
        ev = '{32'd6, 32'd6, 32'd6, 32'd6};
        pulse("t6", 8'd3);

        // Randomized traffic with varying activation density.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 300; i++) begin
                reset = ($urandom_range(0, 199) != 0);
                mode_signed = 1'($urandom);
                sat_en = 1'($urandom);
                clr_ovf = ($urandom_range(0, 9) == 0);
                wt_load_valid = ($urandom_range(0, 99) < 20);
                wt_load_data = BW'($urandom);
                data_in_valid = ($urandom_range(0, 99) < dv_pct[blk]);
                data_in = BW'($urandom);
                for (int k = 0; k < NP; k++) acc_in[k*AW +: AW] = rand_acc();
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
